// File: rtl/butterfly_pkg.sv
// Shared sizing for the first radix-2 DIF butterfly stage: default widths,
// lane count, frame length and the derived half-frame / counter sizes.
package butterfly_pkg;

    localparam int IN_WIDTH_DEF  = 9;
    localparam int OUT_WIDTH_DEF = IN_WIDTH_DEF + 1;
    localparam int NUM_DEF       = 16;
    localparam int DATA_DEF      = 512;

    localparam int FRAME_BEATS_DEF = DATA_DEF / NUM_DEF;
    localparam int H_DEF           = DATA_DEF / (2 * NUM_DEF);

    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int CNT_W_DEF = idx_w(FRAME_BEATS_DEF);

endpackage

// File: rtl/bf_addsub.sv
// One lane of the butterfly: sign-extends a complex pair by one bit and
// forms the full-precision sum and difference.
module bf_addsub
    import butterfly_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic signed [IN_WIDTH-1:0]  a_re,
    input  logic signed [IN_WIDTH-1:0]  a_im,
    input  logic signed [IN_WIDTH-1:0]  b_re,
    input  logic signed [IN_WIDTH-1:0]  b_im,
    output logic signed [OUT_WIDTH-1:0] sum_re,
    output logic signed [OUT_WIDTH-1:0] sum_im,
    output logic signed [OUT_WIDTH-1:0] dif_re,
    output logic signed [OUT_WIDTH-1:0] dif_im
);

    function automatic logic signed [OUT_WIDTH-1:0] sext(input logic signed [IN_WIDTH-1:0] x);
        return OUT_WIDTH'(x);
    endfunction

    // The extra output bit absorbs the carry, so no wrap or clip is possible.
    assign sum_re = sext(a_re) + sext(b_re);
    assign sum_im = sext(a_im) + sext(b_im);
    assign dif_re = sext(a_re) - sext(b_re);
    assign dif_im = sext(a_im) - sext(b_im);

endmodule

// File: rtl/butterfly.sv
// First radix-2 DIF stage of a DATA-point FFT: buffers the first half-frame,
// then pairs each second-half beat with its stored partner, one clock latency.
module butterfly
    import butterfly_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int NUM       = NUM_DEF,
    parameter int DATA      = DATA_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic signed [IN_WIDTH-1:0]  din_i [NUM-1:0],
    input  logic signed [IN_WIDTH-1:0]  din_q [NUM-1:0],
    input  logic                        valid_in,
    output logic signed [OUT_WIDTH-1:0] do1_re [NUM-1:0],
    output logic signed [OUT_WIDTH-1:0] do1_im [NUM-1:0],
    output logic signed [OUT_WIDTH-1:0] do2_re [NUM-1:0],
    output logic signed [OUT_WIDTH-1:0] do2_im [NUM-1:0],
    output logic                        valid_out
);

    localparam int BEATS = DATA / NUM;
    localparam int H     = DATA / (2 * NUM);
    localparam int CW    = idx_w(BEATS);
    localparam int HW    = idx_w(H);

    logic [CW-1:0] beat_cnt;
    logic          second_half;
    logic [HW-1:0] wr_idx;
    logic [HW-1:0] rd_idx;

    logic signed [IN_WIDTH-1:0] buf_i [H-1:0][NUM-1:0];
    logic signed [IN_WIDTH-1:0] buf_q [H-1:0][NUM-1:0];

    logic signed [OUT_WIDTH-1:0] sum_re_p0 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] sum_im_p0 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] dif_re_p0 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] dif_im_p0 [NUM-1:0];

    logic signed [OUT_WIDTH-1:0] sum_re_p1 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] sum_im_p1 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] dif_re_p1 [NUM-1:0];
    logic signed [OUT_WIDTH-1:0] dif_im_p1 [NUM-1:0];
    logic                        vld_p1;

    assign second_half = (beat_cnt >= CW'(H));
    assign wr_idx      = HW'(beat_cnt);
    assign rd_idx      = HW'(beat_cnt - CW'(H));

    // Stage p0: half-frame store and combinational butterflies.
    always_ff @(posedge clk) begin
        if (valid_in && !rstn && !second_half) begin
            buf_i[wr_idx] <= din_i;
            buf_q[wr_idx] <= din_q;
        end
    end

    for (genvar j = 0; j < NUM; j++) begin : g_lane
        bf_addsub #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .a_re   (buf_i[rd_idx][j]),
            .a_im   (buf_q[rd_idx][j]),
            .b_re   (din_i[j]),
            .b_im   (din_q[j]),
            .sum_re (sum_re_p0[j]),
            .sum_im (sum_im_p0[j]),
            .dif_re (dif_re_p0[j]),
            .dif_im (dif_im_p0[j])
        );
    end

    // Stage p1: registered outputs, held between second-half beats.
    always_ff @(posedge clk) begin
        if (rstn) begin
            beat_cnt <= '0;
            vld_p1   <= 1'b0;
            for (int j = 0; j < NUM; j++) begin
                sum_re_p1[j] <= '0;
                sum_im_p1[j] <= '0;
                dif_re_p1[j] <= '0;
                dif_im_p1[j] <= '0;
            end
        end else begin
            vld_p1 <= valid_in && second_half;
            if (valid_in) begin
                beat_cnt <= (beat_cnt == CW'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
                if (second_half) begin
                    sum_re_p1 <= sum_re_p0;
                    sum_im_p1 <= sum_im_p0;
                    dif_re_p1 <= dif_re_p0;
                    dif_im_p1 <= dif_im_p0;
                end
            end
        end
    end

    assign do1_re    = sum_re_p1;
    assign do1_im    = sum_im_p1;
    assign do2_re    = dif_re_p1;
    assign do2_im    = dif_im_p1;
    assign valid_out = vld_p1;

endmodule

// File: tb/tb_butterfly.sv
// Randomized bench for butterfly: a frame-level model predicts every output beat
// from x[n-DATA/2] +/- x[n]; a negedge checker compares each cycle.
module tb_butterfly;
    import butterfly_pkg::*;

    localparam int IW    = IN_WIDTH_DEF;
    localparam int OW    = OUT_WIDTH_DEF;
    localparam int N     = NUM_DEF;
    localparam int D     = DATA_DEF;
    localparam int H     = D / (2 * N);
    localparam int BEATS = D / N;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 valid_in;
    logic signed [IW-1:0] din_i [N-1:0];
    logic signed [IW-1:0] din_q [N-1:0];
    logic signed [OW-1:0] do1_re [N-1:0];
    logic signed [OW-1:0] do1_im [N-1:0];
    logic signed [OW-1:0] do2_re [N-1:0];
    logic signed [OW-1:0] do2_im [N-1:0];
    logic                 valid_out;

    always #5 clk = ~clk;

    butterfly #(
        .IN_WIDTH  (IW),
        .OUT_WIDTH (OW),
        .NUM       (N),
        .DATA      (D)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .din_i     (din_i),
        .din_q     (din_q),
        .valid_in  (valid_in),
        .do1_re    (do1_re),
        .do1_im    (do1_im),
        .do2_re    (do2_re),
        .do2_im    (do2_im),
        .valid_out (valid_out)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic rst_q     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_q <= rstn;

    // Reference model: the frame as sample indices, plus expected output beats.
    int xi [D];
    int xq [D];
    int pos = 0;
    int q1r [$];
    int q1i [$];
    int q2r [$];
    int q2i [$];
    int l1r [N];
    int l1i [N];
    int l2r [N];
    int l2i [N];
    int bi [N];
    int bq [N];
    int valid_cnt = 0;
    int first_v   = -1;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endfunction

    task automatic send();
        for (int j = 0; j < N; j++) begin
            int n;
            n = pos * N + j;
            xi[n] = bi[j];
            xq[n] = bq[j];
            din_i[j] = IW'(bi[j]);
            din_q[j] = IW'(bq[j]);
            if (pos >= H) begin
                q1r.push_back(xi[n - D/2] + xi[n]);
                q1i.push_back(xq[n - D/2] + xq[n]);
                q2r.push_back(xi[n - D/2] - xi[n]);
                q2i.push_back(xq[n - D/2] - xq[n]);
            end
        end
        pos = (pos + 1) % BEATS;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic scramble_din();
        for (int j = 0; j < N; j++) begin
            din_i[j] = IW'($urandom);
            din_q[j] = IW'($urandom);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            valid_in = 1'b0;
            scramble_din();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b1;
        valid_in = 1'b1;
        scramble_din();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        valid_in = 1'b0;
        pos = 0;
    endtask

    task automatic rand_beat();
        for (int j = 0; j < N; j++) begin
            bi[j] = int'($urandom_range(0, 511)) - 256;
            bq[j] = int'($urandom_range(0, 511)) - 256;
        end
        send();
    endtask

    task automatic rand_frame(input bit gaps);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps && ($urandom % 3 == 0)) idle(int'($urandom_range(1, 3)));
            rand_beat();
        end
    endtask

    task automatic const_frame(input int first, input int second);
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < N; j++) begin
                bi[j] = (b < H) ? first : second;
                bq[j] = (b < H) ? first : second;
            end
            send();
        end
    endtask

    // Per-cycle checker: reset zeros, predicted beats on valid, hold otherwise.
    always @(negedge clk) begin
        if (rst_q) begin
            chk("reset_valid", int'(valid_out), 0);
            for (int j = 0; j < N; j++) begin
                chk("reset_do1_re", int'(do1_re[j]), 0);
                chk("reset_do1_im", int'(do1_im[j]), 0);
                chk("reset_do2_re", int'(do2_re[j]), 0);
                chk("reset_do2_im", int'(do2_im[j]), 0);
                l1r[j] = 0; l1i[j] = 0; l2r[j] = 0; l2i[j] = 0;
            end
            q1r.delete(); q1i.delete(); q2r.delete(); q2i.delete();
        end else if (valid_out) begin
            valid_cnt++;
            if (first_v < 0) first_v = cyc;
            if (q1r.size() < N) begin
                chk("spurious_valid", 1, 0);
            end else begin
                for (int j = 0; j < N; j++) begin
                    l1r[j] = q1r.pop_front();
                    l1i[j] = q1i.pop_front();
                    l2r[j] = q2r.pop_front();
                    l2i[j] = q2i.pop_front();
                    chk("do1_re", int'(do1_re[j]), l1r[j]);
                    chk("do1_im", int'(do1_im[j]), l1i[j]);
                    chk("do2_re", int'(do2_re[j]), l2r[j]);
                    chk("do2_im", int'(do2_im[j]), l2i[j]);
                end
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                chk("hold_do1_re", int'(do1_re[j]), l1r[j]);
                chk("hold_do1_im", int'(do1_im[j]), l1i[j]);
                chk("hold_do2_re", int'(do2_re[j]), l2r[j]);
                chk("hold_do2_im", int'(do2_im[j]), l2i[j]);
            end
        end
    end

    initial begin
        int x0;
        int v0;
        rstn = 1'b1;
        valid_in = 1'b0;
        scramble_din();
        do_reset();
        chk("lit_reset_valid", int'(valid_out), 0);
        chk("lit_reset_do1", int'(do1_re[0]), 0);
        chk("lit_reset_do2", int'(do2_im[N-1]), 0);

        // Ramp frame, gapless.
        first_v = -1;
        v0 = valid_cnt;
        x0 = cyc;
        for (int b = 0; b < BEATS; b++) begin
            for (int j = 0; j < N; j++) begin
                bi[j] = ((b * N + j) % 256) - 128;
                bq[j] = 0;
            end
            send();
        end
        idle(3);
        chk("ramp_latency", first_v - x0, H + 1);
        chk("ramp_beats", valid_cnt - v0, H);
        chk("lit_ramp_do1", int'(do1_re[N-1]), 254);
        chk("lit_ramp_do2", int'(do2_re[0]), 0);

        // Extremes.
        const_frame(-256, -256);
        idle(2);
        chk("lit_ext_do1_re", int'(do1_re[0]), -512);
        chk("lit_ext_do1_im", int'(do1_im[N-1]), -512);
        chk("lit_ext_do2_re", int'(do2_re[0]), 0);
        const_frame(255, -256);
        idle(2);
        chk("lit_ext_do2_re", int'(do2_re[0]), 511);
        chk("lit_ext_do2_im", int'(do2_im[N-1]), 511);
        chk("lit_ext_do1_re", int'(do1_re[0]), -1);

        // Random frame with gaps.
        rand_frame(1'b1);
        idle(2);

        // Back-to-back frames across the wrap.
        v0 = valid_cnt;
        rand_frame(1'b0);
        rand_frame(1'b0);
        idle(3);
        chk("b2b_beats", valid_cnt - v0, 2 * H);

        // Reset after 20 beats, then a fresh frame.
        for (int b = 0; b < 20; b++) rand_beat();
        do_reset();
        v0 = valid_cnt;
        rand_frame(1'b1);
        idle(3);
        chk("post_reset_beats", valid_cnt - v0, H);

        for (int f = 0; f < 3; f++) rand_frame(1'b1);
        idle(5);
        chk("queue_drained", q1r.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/butterfly.md
BUTTERFLY -- requirements
Module: butterfly

Interface
REQ-001 Parameter IN_WIDTH, default 9, SHALL set the signed input sample width (two's complement, 3.6 fixed point).
REQ-002 Parameter OUT_WIDTH, default 10, SHALL set the signed output width and SHALL equal IN_WIDTH+1.
REQ-003 Parameter NUM, default 16, SHALL set the number of parallel sample lanes per beat.
REQ-004 Parameter DATA, default 512, SHALL set the frame length (FFT points) and SHALL be a multiple of 2*NUM.
REQ-005 clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-006 rstn, input, 1: synchronous, active-high reset (asserted = 1, sampled on the clk rising edge).
REQ-007 din_i[NUM-1:0], input, NUM x IN_WIDTH signed: real part of the input samples, lane j = sample beat*NUM+j.
REQ-008 din_q[NUM-1:0], input, NUM x IN_WIDTH signed: imaginary part of the input samples, same lane ordering.
REQ-009 valid_in, input, 1: din_i and din_q hold a valid beat this cycle.
REQ-010 do1_re[NUM-1:0] and do1_im[NUM-1:0], output, NUM x OUT_WIDTH signed: sum outputs, real and imaginary.
REQ-011 do2_re[NUM-1:0] and do2_im[NUM-1:0], output, NUM x OUT_WIDTH signed: difference outputs, real and imaginary.
REQ-012 valid_out, output, 1: the do1 and do2 outputs hold a valid beat this cycle.

Function
REQ-013 The block SHALL perform the first radix-2 DIF stage of a DATA-point FFT: pair x[n] with x[n+DATA/2].
REQ-014 A frame SHALL be DATA/NUM beats (32 by default); a beat counter SHALL advance only on cycles with valid_in=1.
REQ-015 Beats 0..H-1, with H = DATA/(2*NUM) = 16, SHALL be stored in an internal buffer indexed by beat; these beats SHALL produce no output.
REQ-016 On beat H+k (k = 0..H-1), for each lane j the block SHALL compute do1 = buf[k][j] + din[j] and do2 = buf[k][j] - din[j].
REQ-017 The REQ-016 computation SHALL apply separately to the real parts (_re from din_i) and imaginary parts (_im from din_q).
REQ-018 Operands SHALL be sign-extended to OUT_WIDTH before add/subtract; results SHALL be full precision, with no rounding, saturation or overflow.
REQ-019 Outputs SHALL be registered: valid_out SHALL be 1 on the cycle after each second-half beat is sampled (latency 1 clk), otherwise 0.
REQ-020 When valid_out=0, the data outputs SHALL hold their last values.
REQ-021 Gaps (valid_in=0) SHALL be allowed anywhere in a frame; the counter and buffer SHALL hold across gaps.
REQ-022 After beat DATA/NUM-1 the counter SHALL wrap to 0; the next valid beat SHALL start a new frame with no dead cycle.
REQ-023 The block SHALL have no backpressure; every valid beat SHALL be accepted.

Reset
REQ-024 While rstn=1 at a rising edge, the beat counter, valid_out and all do1/do2 outputs SHALL be cleared to 0; buffer contents need not be cleared.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first valid beat after reset SHALL be beat 0.
REQ-026 valid_in SHALL be ignored during the reset cycle.

Structure
REQ-027 A shared package butterfly_pkg SHALL hold the default widths and counts, plus helper localparams (H, frame beat count, counter width).
REQ-028 One sub-module, bf_addsub, SHALL implement a single lane's sign-extend and sum/difference for one real/imag pair; it SHALL be instantiated NUM times via generate.
REQ-029 The half-frame buffer SHALL be an inferred register array of H x NUM x 2 x IN_WIDTH bits.

Verification
REQ-030 Reset: hold rstn=1 for 2 cycles -> valid_out=0 and all outputs 0.
REQ-031 Ramp frame: re=(n mod 256)-128, im=0 for n = 0..511, 32 consecutive beats -> 16 valid beats starting 17 clk after the first beat; each do1_re = 2*re[n], each do2_re = 0.
REQ-032 Extremes: first half all -256 and second half all -256 -> do1 = -512; first half 255 and second half -256 -> do2 = 511; verifies no overflow at 10 bits.
REQ-033 Gaps: insert random valid_in=0 cycles in a frame -> the same outputs as the gapless case; valid_out is never high without a preceding second-half beat.
REQ-034 Back-to-back frames: two frames with no idle cycle -> 32 output beats, all correct, with no corruption at the wrap.
REQ-035 Reset mid-frame after 20 beats, then a full frame -> outputs match the new frame only.
